multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter NONE: all widths fixed (16-bit datapath, 4-bit opcode).
REQ-002 The block SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port In_Opcode, input, 4, instruction bits [3:0] from the instruction register.
REQ-005 The block SHALL have port In_Zero, input, 1, ALU zero flag.
REQ-006 The block SHALL have port In_MemReady, input, 1, memory completion handshake.
REQ-007 The block SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite and ALUSrcA, each output, 1, the datapath control strobe or select of that name.
REQ-008 The block SHALL have ports ALUSrcB, ALUOp, PCSource and MemToReg, each output, 2, the datapath multiplexer selects.
REQ-009 The block SHALL have port Out_State, output, 4, the current state encoding for debug.
REQ-010 The block SHALL have port Out_Illegal, output, 1, sticky illegal-opcode flag.

Function
REQ-011 The block SHALL be a Moore FSM; all outputs SHALL decode from the state register only, except the branch PC enable (REQ-021).
REQ-012 The opcodes SHALL be: 0000 R-type, 0010 lw, 0011 sw, 0100 addi, 0101 si, 1001 beq, 1110 lui; all others are illegal.
REQ-013 The encodings SHALL be: ALUSrcB 00=B, 01=constant 2, 10=imm, 11=imm<<1. ALUOp 00=add, 01=sub, 10=funct-decoded, 11=opcode-decoded.
REQ-014 FETCH SHALL assert MemRead, IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; it SHALL hold while In_MemReady=0 with IRWrite/PCWrite gated low; on In_MemReady=1 it SHALL go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target) and branch on opcode: lw/sw->MEMADDR, R-type->REXEC, addi/si->IEXEC, beq->BRANCH, lui->LUIWB, illegal->HALT.
REQ-016 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or to MEMWR for sw.
REQ-017 MEMRD SHALL assert IorD and MemRead and SHALL wait for In_MemReady, then go to MEMWB; MEMWB SHALL assert RegWrite with MemToReg=01 and then go to FETCH.
REQ-018 MEMWR SHALL assert IorD and MemWrite and SHALL wait for In_MemReady, then go to FETCH.
REQ-019 REXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-020 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=11, then go to ALUWB; ALUWB SHALL assert RegWrite with MemToReg=00 and then go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, with effective PC enable = PCWrite | (PCWriteCond & In_Zero), then go to FETCH.
REQ-022 LUIWB SHALL assert RegWrite with MemToReg=10 (imm path), then go to FETCH.
REQ-023 HALT SHALL be absorbing, with all strobes low and Out_Illegal=1, until reset.
REQ-024 Latencies with In_MemReady tied high SHALL be: R/addi/si 4 cycles, lw 5, sw 4, beq 3, lui 3.
REQ-025 In every state not listed as asserting a strobe, that strobe SHALL be 0; MemRead and MemWrite SHALL never be asserted together.
REQ-026 An unused state encoding SHALL transition to FETCH on the next clock.

Reset
REQ-027 Reset low SHALL immediately force state FETCH, Out_Illegal=0 and all strobes to their FETCH values, with IRWrite and PCWrite gated low while Reset=0.
REQ-028 Reset asserted mid-instruction (including during a memory wait) SHALL abandon the instruction, and no RegWrite or MemWrite SHALL occur afterward.

Structure
REQ-029 The opcode, state, ALUSrcB and ALUOp encodings SHALL live in a shared package (cpu_defs) that is also used by the ALU control.
REQ-030 Output decoding SHALL be a sub-module, control_decode (state -> strobes), with the state register and next-state logic in the top.

Verification
REQ-031 Reset, release, opcode 0000, MemReady=1 -> states FETCH,DECODE,REXEC,ALUWB; ALUOp=10 in REXEC; RegWrite=1 only in ALUWB.
REQ-032 lw (0010) with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles; MemRead and IorD steady; MEMWB follows with MemToReg=01.
REQ-033 beq (1001): Zero=1 -> PC enable=1 in BRANCH; repeated with Zero=0 -> PC enable=0; both runs return to FETCH.
REQ-034 Opcode 1111 -> HALT, Out_Illegal=1, strobes 0 for 10 cycles; Reset low -> FETCH, Out_Illegal=0.
REQ-035 sw (0011), Reset asserted during MEMWR wait -> MemWrite drops asynchronously and the FSM is in FETCH.
REQ-036 Random legal opcode stream -> MemRead&MemWrite never 1 together, and per-instruction cycle counts match REQ-024.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode, state and ALU-control encodings for the multicycle CPU
package cpu_defs;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SI    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b1001;
  localparam logic [3:0] OP_LUI   = 4'b1110;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_TWO     = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH1 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_SUB    = 2'b01,
    ALUOP_FUNCT  = 2'b10,
    ALUOP_OPCODE = 2'b11
  } alu_op_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_IMM = 2'b10;

  // Encodings 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    REXEC   = 4'd6,
    IEXEC   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    LUIWB   = 4'd10,
    HALT    = 4'd11
  } state_t;

  function automatic logic is_legal_opcode(input logic [3:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI) ||
           (op == OP_SI) || (op == OP_BEQ) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - state-to-strobe decode for the multicycle controller
module control_decode
  import cpu_defs::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       rst_n,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] mem_to_reg,
  output logic       illegal
);

  // The fetch commit strobes only fire once memory has answered and reset is released.
  logic fetch_go;
  assign fetch_go = mem_ready & rst_n;

  // Moore decode: every strobe defaults low, each state raises only its own.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    mem_to_reg    = M2R_ALU;
    illegal       = 1'b0;
    case (state_t'(state))
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = fetch_go;
        pc_write  = fetch_go;
        alu_src_b = SRCB_TWO;
      end
      DECODE:  alu_src_b = SRCB_IMM_SH1;
      MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MEM;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_OPCODE;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_TARGET;
      end
      LUIWB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_IMM;
      end
      HALT:    illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM: state register and next-state logic
module multicycle_control
  import cpu_defs::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] In_Opcode,
  input  logic       In_Zero,
  input  logic       In_MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] MemToReg,
  output logic [3:0] Out_State,
  output logic       Out_Illegal
);

  state_t state;
  state_t next_state;

  // The branch decision itself is taken in the datapath: PC enable = PCWrite | (PCWriteCond & In_Zero).
  logic unused_zero;
  assign unused_zero = In_Zero;

  // State register; reset abandons whatever instruction is in flight.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state: opcode dispatch in DECODE, memory waits in FETCH/MEMRD/MEMWR, HALT absorbs.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = In_MemReady ? DECODE : FETCH;
      DECODE: begin
        if (!is_legal_opcode(In_Opcode)) next_state = HALT;
        else begin
          case (In_Opcode)
            OP_LW, OP_SW:   next_state = MEMADDR;
            OP_RTYPE:       next_state = REXEC;
            OP_ADDI, OP_SI: next_state = IEXEC;
            OP_BEQ:         next_state = BRANCH;
            OP_LUI:         next_state = LUIWB;
            default:        next_state = HALT;
          endcase
        end
      end
      MEMADDR: next_state = (In_Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   next_state = In_MemReady ? MEMWB : MEMRD;
      MEMWR:   next_state = In_MemReady ? FETCH : MEMWR;
      REXEC:   next_state = ALUWB;
      IEXEC:   next_state = ALUWB;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  assign Out_State = state;

  control_decode u_decode (
    .state         (state),
    .mem_ready     (In_MemReady),
    .rst_n         (Reset),
    .pc_write      (PCWrite),
    .pc_write_cond (PCWriteCond),
    .i_or_d        (IorD),
    .mem_read      (MemRead),
    .mem_write     (MemWrite),
    .ir_write      (IRWrite),
    .reg_write     (RegWrite),
    .alu_src_a     (ALUSrcA),
    .alu_src_b     (ALUSrcB),
    .alu_op        (ALUOp),
    .pc_source     (PCSource),
    .mem_to_reg    (MemToReg),
    .illegal       (Out_Illegal)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  import cpu_defs::*;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] In_Opcode = 4'h0;
  logic       In_Zero = 1'b0;
  logic       In_MemReady = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource, MemToReg;
  logic [3:0] Out_State;
  logic       Out_Illegal;

  multicycle_control dut (
    .CLK(CLK), .Reset(Reset), .In_Opcode(In_Opcode), .In_Zero(In_Zero), .In_MemReady(In_MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .MemToReg(MemToReg), .Out_State(Out_State), .Out_Illegal(Out_Illegal)
  );

  always #5 CLK = ~CLK;

  logic        pc_en;
  logic [16:0] ctl;
  assign pc_en = PCWrite | (PCWriteCond & In_Zero);
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource, MemToReg, Out_Illegal};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [3:0] st; logic rdy; } sched_t;
  sched_t sched[$];

  typedef struct { logic [3:0] op; logic zero; int fw; int mw; int exp_rw; int exp_mw; int exp_pc; } vec_t;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference strobe table written from the control-state descriptions.
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic rst_n);
    logic pcw, pwc, iord, mr, mw, irw, rw, srca, ill;
    logic [1:0] srcb, aop, pcs, m2r;
    {pcw, pwc, iord, mr, mw, irw, rw, srca, ill} = '0;
    {srcb, aop, pcs, m2r} = '0;
    case (st)
      FETCH:   begin mr = 1; irw = rdy & rst_n; pcw = rdy & rst_n; srcb = 2'b01; end
      DECODE:  srcb = 2'b11;
      MEMADDR: begin srca = 1; srcb = 2'b10; end
      MEMRD:   begin iord = 1; mr = 1; end
      MEMWB:   begin rw = 1; m2r = 2'b01; end
      MEMWR:   begin iord = 1; mw = 1; end
      REXEC:   begin srca = 1; aop = 2'b10; end
      IEXEC:   begin srca = 1; srcb = 2'b10; aop = 2'b11; end
      ALUWB:   rw = 1;
      BRANCH:  begin srca = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      LUIWB:   begin rw = 1; m2r = 2'b10; end
      HALT:    ill = 1;
      default: ;
    endcase
    return {pcw, pwc, iord, mr, mw, irw, rw, srca, srcb, aop, pcs, m2r, ill};
  endfunction

  function automatic int latency(input logic [3:0] op);
    case (op)
      OP_LW:          return 5;
      OP_BEQ, OP_LUI: return 3;
      default:        return 4;
    endcase
  endfunction

  task automatic build(input logic [3:0] op, input int fw, input int mw);
    sched.delete();
    for (int i = 0; i < fw; i++) sched.push_back('{FETCH, 1'b0});
    sched.push_back('{FETCH, 1'b1});
    sched.push_back('{DECODE, 1'b1});
    case (op)
      OP_LW: begin
        sched.push_back('{MEMADDR, 1'b1});
        for (int i = 0; i < mw; i++) sched.push_back('{MEMRD, 1'b0});
        sched.push_back('{MEMRD, 1'b1});
        sched.push_back('{MEMWB, 1'b1});
      end
      OP_SW: begin
        sched.push_back('{MEMADDR, 1'b1});
        for (int i = 0; i < mw; i++) sched.push_back('{MEMWR, 1'b0});
        sched.push_back('{MEMWR, 1'b1});
      end
      OP_RTYPE:      begin sched.push_back('{REXEC, 1'b1}); sched.push_back('{ALUWB, 1'b1}); end
      OP_ADDI, OP_SI: begin sched.push_back('{IEXEC, 1'b1}); sched.push_back('{ALUWB, 1'b1}); end
      OP_BEQ:        sched.push_back('{BRANCH, 1'b1});
      OP_LUI:        sched.push_back('{LUIWB, 1'b1});
      default:       for (int i = 0; i < 10; i++) sched.push_back('{HALT, 1'b1});
    endcase
  endtask

  // Pops one expected state per cycle; called at a negedge with the DUT in FETCH.
  task automatic run_sched(input string nm, output int rw_n, output int mw_n, output int pc_n);
    sched_t e;
    rw_n = 0; mw_n = 0; pc_n = 0;
    while (sched.size() > 0) begin
      e = sched.pop_front();
      In_MemReady = e.rdy;
      #1;
      check({nm, " state"}, 32'(Out_State), 32'(e.st));
      check({nm, " ctl"}, 32'(ctl), 32'(exp_ctl(e.st, e.rdy, 1'b1)));
      if (RegWrite) rw_n++;
      if (MemWrite) mw_n++;
      if (pc_en && Out_State != FETCH) pc_n++;
      @(negedge CLK);
    end
    In_MemReady = 1'b1;
  endtask

  task automatic reset_mid(input logic [3:0] op, input logic [3:0] mst, input string nm);
    In_Opcode = op;
    In_MemReady = 1'b1;
    repeat (3) @(negedge CLK);
    In_MemReady = 1'b0;
    #1;
    check({nm, " wait state"}, 32'(Out_State), 32'(mst));
    @(negedge CLK);
    #1;
    check({nm, " still waiting"}, 32'(ctl), 32'(exp_ctl(mst, 1'b0, 1'b1)));
    #1 Reset = 1'b0;
    #1;
    check({nm, " async state"}, 32'(Out_State), 32'(FETCH));
    check({nm, " async ctl"}, 32'(ctl), 32'(exp_ctl(FETCH, 1'b0, 1'b0)));
    repeat (2) begin
      @(negedge CLK);
      #1 check({nm, " held writes"}, 32'(RegWrite | MemWrite), 32'd0);
    end
    @(negedge CLK);
    Reset = 1'b1;
    repeat (3) begin
      #1 check({nm, " after writes"}, 32'({Out_State, RegWrite, MemWrite}), 32'({FETCH, 2'b00}));
      @(negedge CLK);
    end
    In_MemReady = 1'b1;
  endtask

  initial begin
    int rw_n, mw_n, pc_n, cyc;
    logic [3:0] op;
    logic [3:0] legal[7];
    logic both;
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SI, OP_BEQ, OP_LUI};

    vecs[0] = '{OP_RTYPE, 1'b0, 0, 0, 1, 0, 0};
    vecs[1] = '{OP_LW,    1'b0, 0, 3, 1, 0, 0};
    vecs[2] = '{OP_SW,    1'b0, 1, 2, 0, 3, 0};
    vecs[3] = '{OP_ADDI,  1'b1, 0, 0, 1, 0, 0};
    vecs[4] = '{OP_SI,    1'b0, 2, 0, 1, 0, 0};
    vecs[5] = '{OP_BEQ,   1'b1, 0, 0, 0, 0, 1};
    vecs[6] = '{OP_BEQ,   1'b0, 0, 0, 0, 0, 0};
    vecs[7] = '{OP_LUI,   1'b0, 0, 0, 1, 0, 0};

    // Reset: FETCH values with the commit strobes gated off.
    #1 Reset = 1'b0;
    #1;
    check("reset state", 32'(Out_State), 32'(FETCH));
    check("reset ctl", 32'(ctl), 32'(exp_ctl(FETCH, 1'b1, 1'b0)));
    @(negedge CLK);
    #1 check("reset held", 32'(Out_State), 32'(FETCH));
    In_MemReady = 1'b0;
    Reset = 1'b1;
    #1 check("release stall ctl", 32'(ctl), 32'(exp_ctl(FETCH, 1'b0, 1'b1)));
    @(negedge CLK);
    check("release stall state", 32'(Out_State), 32'(FETCH));

    for (int i = 0; i < 8; i++) begin
      In_Opcode = vecs[i].op;
      In_Zero = vecs[i].zero;
      build(vecs[i].op, vecs[i].fw, vecs[i].mw);
      run_sched($sformatf("vec%0d", i), rw_n, mw_n, pc_n);
      check($sformatf("vec%0d regwrites", i), 32'(rw_n), 32'(vecs[i].exp_rw));
      check($sformatf("vec%0d memwrites", i), 32'(mw_n), 32'(vecs[i].exp_mw));
      check($sformatf("vec%0d pc_en", i), 32'(pc_n), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d return", i), 32'(Out_State), 32'(FETCH));
    end

    // Illegal opcode: HALT absorbs for 10 cycles, then reset clears it.
    In_Opcode = 4'hF;
    build(4'hF, 0, 0);
    run_sched("halt", rw_n, mw_n, pc_n);
    check("halt writes", 32'(rw_n + mw_n), 32'd0);
    #2 Reset = 1'b0;
    In_MemReady = 1'b0;
    #1;
    check("halt reset state", 32'(Out_State), 32'(FETCH));
    check("halt reset illegal", 32'(Out_Illegal), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    In_MemReady = 1'b1;

    reset_mid(OP_SW, MEMWR, "sw reset");
    reset_mid(OP_LW, MEMRD, "lw reset");

    // Random legal stream: latency per opcode and read/write exclusion.
    for (int n = 0; n < 25; n++) begin
      op = legal[$urandom_range(0, 6)];
      In_Opcode = op;
      In_Zero = 1'($urandom_range(0, 1));
      In_MemReady = 1'b1;
      cyc = 0;
      both = 1'b0;
      do begin
        #1 both = both | (MemRead & MemWrite);
        cyc++;
        @(negedge CLK);
      end while (Out_State != FETCH && cyc < 20);
      check($sformatf("rand%0d op%0h cycles", n, op), 32'(cyc), 32'(latency(op)));
      check($sformatf("rand%0d rd_wr", n), 32'(both), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
